sccb_table_loader: RTL and testbench

SCCB_TABLE_LOADER -- requirements
Module: sccb_table_loader

---
 rtl/sccb_table_loader.sv | 239 +++++++++++++++++++++++
 tb/tb_sccb_table_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_table_loader.sv
// Walks a BRAM-resident register table and replays each entry as one SCCB/I2C
// write transaction (command + address/data bytes) through an external bus
// master. Supports delay entries, per-entry retry on missed ACK, and a
// zero-entry terminator.
module sccb_table_loader #(
   parameter int          RAM_DEPTH    = 256,
   parameter int          ADDR_BYTES   = 2,
   parameter int          DATA_BYTES   = 1,
   parameter logic [6:0]  DEV_ADDR     = 7'h3C,
   parameter int          BRAM_LATENCY = 2,
   parameter int          MAX_RETRY    = 3,
   parameter int          DELAY_UNIT   = 100000,
   localparam int         AW           = $clog2(RAM_DEPTH),
   localparam int         EW           = 8 * (ADDR_BYTES + DATA_BYTES)
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          init_valid,
   output logic          init_ready,
   output logic [AW-1:0] bram_addr,
   input  logic [EW-1:0] bram_dout,
   output logic [6:0]    cmd_address,
   output logic          cmd_start,
   output logic          cmd_write_multiple,
   output logic          cmd_stop,
   output logic          cmd_valid,
   input  logic          cmd_ready,
   output logic [7:0]    data_tdata,
   output logic          data_tvalid,
   input  logic          data_tready,
   output logic          data_tlast,
   input  logic          master_busy,
   input  logic          missed_ack,
   output logic          done,
   output logic          error,
   output logic [15:0]   entries_written,
   output logic [AW-1:0] fail_index
);

   localparam int NB  = ADDR_BYTES + DATA_BYTES;
   localparam int AFW = 8 * ADDR_BYTES;
   localparam int DFW = 8 * DATA_BYTES;
   localparam int DCW = DFW + $clog2(DELAY_UNIT + 1);
   localparam int RCW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam int LCW = (BRAM_LATENCY < 1) ? 1 : $clog2(BRAM_LATENCY + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_WAIT_RD, S_DECODE, S_CMD,
      S_SEND, S_WAIT_DONE, S_DELAY, S_DONE, S_ERROR
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   index_q, index_d;
   logic [RCW-1:0]  retries_q, retries_d;
   logic            nack_q, nack_d;
   logic [1:0]      byte_q, byte_d;
   logic [EW-1:0]   entry_q, entry_d;
   logic [LCW-1:0]  rd_cnt_q, rd_cnt_d;
   logic [DCW-1:0]  delay_q, delay_d;
   logic [15:0]     written_q, written_d;
   logic            error_q, error_d;
   logic [AW-1:0]   fail_q, fail_d;

   logic [AFW-1:0]  dout_addr;
   logic [DFW-1:0]  dout_data;
   logic [DCW-1:0]  delay_load;
   logic [7:0]      send_byte;
   logic            last_index;
   logic            last_byte;
   logic            advance;

   assign dout_addr  = bram_dout[EW-1 -: AFW];
   assign dout_data  = bram_dout[DFW-1:0];
   assign delay_load = (dout_data == '0) ? DCW'(1) : DCW'(dout_data) * DCW'(DELAY_UNIT);
   assign last_index = (index_q == AW'(RAM_DEPTH - 1));
   assign last_byte  = (byte_q == 2'(NB - 1));

   assign bram_addr          = index_q;
   assign cmd_start          = cmd_valid;
   assign cmd_write_multiple = cmd_valid;
   assign cmd_stop           = cmd_valid;
   assign cmd_address        = cmd_valid ? DEV_ADDR : '0;
   assign entries_written    = written_q;
   assign error              = error_q;
   assign fail_index         = fail_q;

   // Select the current outgoing byte, most significant byte first.
   always_comb begin
      send_byte = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         if (byte_q == 2'(i)) send_byte = entry_q[EW-1-8*i -: 8];
      end
   end

   // State and datapath registers; reset aborts any transfer in progress.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q   <= S_IDLE;
         index_q   <= '0;
         retries_q <= '0;
         nack_q    <= 1'b0;
         byte_q    <= '0;
         entry_q   <= '0;
         rd_cnt_q  <= '0;
         delay_q   <= '0;
         written_q <= '0;
         error_q   <= 1'b0;
         fail_q    <= '0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         retries_q <= retries_d;
         nack_q    <= nack_d;
         byte_q    <= byte_d;
         entry_q   <= entry_d;
         rd_cnt_q  <= rd_cnt_d;
         delay_q   <= delay_d;
         written_q <= written_d;
         error_q   <= error_d;
         fail_q    <= fail_d;
      end
   end

   // Next-state and output decode; bus outputs are only non-zero in CMD/SEND.
   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      retries_d   = retries_q;
      nack_d      = nack_q;
      byte_d      = byte_q;
      entry_d     = entry_q;
      rd_cnt_d    = rd_cnt_q;
      delay_d     = delay_q;
      written_d   = written_q;
      error_d     = error_q;
      fail_d      = fail_q;
      advance     = 1'b0;
      init_ready  = 1'b0;
      cmd_valid   = 1'b0;
      data_tvalid = 1'b0;
      data_tlast  = 1'b0;
      data_tdata  = '0;
      done        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            init_ready = 1'b1;
            if (init_valid) begin
               state_d   = S_FETCH;
               index_d   = '0;
               retries_d = '0;
               written_d = '0;
               error_d   = 1'b0;
            end
         end
         S_FETCH: begin
            rd_cnt_d = '0;
            state_d  = (BRAM_LATENCY == 0) ? S_DECODE : S_WAIT_RD;
         end
         S_WAIT_RD: begin
            if (rd_cnt_q == LCW'(BRAM_LATENCY - 1)) state_d = S_DECODE;
            else rd_cnt_d = rd_cnt_q + LCW'(1);
         end
         S_DECODE: begin
            entry_d = bram_dout;
            if (bram_dout == '0) begin
               state_d = S_DONE;
            end else if (dout_addr == '1) begin
               delay_d = delay_load;
               state_d = S_DELAY;
            end else begin
               nack_d  = 1'b0;
               state_d = S_CMD;
            end
         end
         S_DELAY: begin
            if (delay_q == DCW'(1)) advance = 1'b1;
            else delay_d = delay_q - DCW'(1);
         end
         S_CMD: begin
            cmd_valid = 1'b1;
            nack_d    = nack_q | missed_ack;
            if (cmd_ready) begin
               byte_d  = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            data_tvalid = 1'b1;
            data_tdata  = send_byte;
            data_tlast  = last_byte;
            nack_d      = nack_q | missed_ack;
            if (data_tready) begin
               if (last_byte) state_d = S_WAIT_DONE;
               else byte_d = byte_q + 2'd1;
            end
         end
         S_WAIT_DONE: begin
            nack_d = nack_q | missed_ack;
            if (!master_busy) begin
               if (!(nack_q | missed_ack)) begin
                  if (written_q != '1) written_d = written_q + 16'd1;
                  advance = 1'b1;
               end else if (retries_q < RCW'(MAX_RETRY)) begin
                  retries_d = retries_q + RCW'(1);
                  nack_d    = 1'b0;
                  state_d   = S_CMD;
               end else begin
                  error_d = 1'b1;
                  fail_d  = index_q;
                  state_d = S_ERROR;
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         S_ERROR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Shared step to the next table entry; the table never wraps to 0.
      if (advance) begin
         retries_d = '0;
         if (last_index) begin
            state_d = S_DONE;
         end else begin
            index_d = index_q + AW'(1);
            state_d = S_FETCH;
         end
      end
   end

endmodule

// File: tb/tb_sccb_table_loader.sv
// Directed bench for sccb_table_loader: BRAM model with 2-cycle latency,
// a bus-master agent with back-pressure, missed-ACK injection and busy time.
module tb_sccb_table_loader;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        init_valid = 1'b0;
   logic        init_ready;
   logic [1:0]  bram_addr;
   logic [23:0] bram_dout;
   logic [6:0]  cmd_address;
   logic        cmd_start, cmd_write_multiple, cmd_stop, cmd_valid;
   logic        cmd_ready = 1'b1;
   logic [7:0]  data_tdata;
   logic        data_tvalid;
   logic        data_tready = 1'b1;
   logic        data_tlast;
   logic        master_busy = 1'b0;
   logic        missed_ack = 1'b0;
   logic        done, error;
   logic [15:0] entries_written;
   logic [1:0]  fail_index;

   sccb_table_loader #(
      .RAM_DEPTH (4),
      .DELAY_UNIT(10)
   ) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .init_valid        (init_valid),
      .init_ready        (init_ready),
      .bram_addr         (bram_addr),
      .bram_dout         (bram_dout),
      .cmd_address       (cmd_address),
      .cmd_start         (cmd_start),
      .cmd_write_multiple(cmd_write_multiple),
      .cmd_stop          (cmd_stop),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .data_tdata        (data_tdata),
      .data_tvalid       (data_tvalid),
      .data_tready       (data_tready),
      .data_tlast        (data_tlast),
      .master_busy       (master_busy),
      .missed_ack        (missed_ack),
      .done              (done),
      .error             (error),
      .entries_written   (entries_written),
      .fail_index        (fail_index)
   );

   always #5 clk_in = ~clk_in;

   // BRAM model: two-register read pipeline
   logic [23:0] mem [0:3];
   logic [23:0] p1 = '0, p2 = '0;
   always @(posedge clk_in) begin
      p1 <= mem[bram_addr];
      p2 <= p1;
   end
   assign bram_dout = p2;

   int tests = 0, fails = 0;
   logic [8:0] gotq[$];
   logic [8:0] expq[$];
   int cmd_cnt = 0, frame_pos = 0, busy_cnt = 0, nack_left = 0;
   int stall_cnt = 0, stall_seen = 0, stall_bad = 0, gap = 0;
   logic [7:0] frame_first = '0;
   logic stall_arm = 0, meas = 0, seen_nz = 0, wrapped = 0, cmd_bad = 0;
   int done_cnt = 0;
   logic ended = 0;

   // Bus agent: samples at negedge, then sets inputs for the next posedge
   always @(negedge clk_in) begin
      missed_ack = 1'b0;
      if (busy_cnt > 0) busy_cnt--;
      master_busy = (busy_cnt > 0);
      if (!init_ready && bram_addr != 2'd0) seen_nz = 1'b1;
      if (!init_ready && seen_nz && bram_addr == 2'd0) wrapped = 1'b1;
      if (cmd_valid && (cmd_address != 7'h3C || !cmd_start || !cmd_write_multiple || !cmd_stop))
         cmd_bad = 1'b1;
      if (meas) begin
         if (cmd_valid) meas = 1'b0;
         else gap++;
      end
      if (stall_arm && data_tvalid && frame_pos == 1) begin
         stall_cnt = 5;
         stall_arm = 1'b0;
      end
      if (stall_cnt > 0) begin
         data_tready = 1'b0;
         stall_cnt--;
         if (data_tvalid && data_tdata == 8'h08) stall_seen++;
         else stall_bad++;
      end else begin
         data_tready = 1'b1;
      end
      if (cmd_valid && cmd_ready) cmd_cnt++;
      if (data_tvalid && data_tready) begin
         if (frame_pos == 0) frame_first = data_tdata;
         gotq.push_back({data_tlast, data_tdata});
         if (data_tlast) begin
            frame_pos   = 0;
            busy_cnt    = 3;
            master_busy = 1'b1;
            if (frame_first == 8'h31 && nack_left > 0) begin
               nack_left--;
               missed_ack = 1'b1;
            end
         end else begin
            frame_pos++;
         end
      end
      if (init_valid && init_ready) begin
         meas = 1'b1;
         gap  = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_bytes(input string tag);
      check({tag, "_count"}, gotq.size(), expq.size());
      for (int i = 0; i < expq.size(); i++)
         if (i < gotq.size()) check($sformatf("%s_b%0d", tag, i), 32'(gotq[i]), 32'(expq[i]));
   endtask

   task automatic start_run();
      gotq.delete();
      cmd_cnt  = 0;
      done_cnt = 0;
      seen_nz  = 1'b0;
      wrapped  = 1'b0;
      ended    = 1'b0;
      @(posedge clk_in); #1 init_valid = 1'b1;
      @(posedge clk_in); #1 init_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk_in);
         if (done) done_cnt++;
         if (init_ready) begin
            ended = 1'b1;
            break;
         end
      end
      check({tag, "_finished"}, 32'(ended), 32'd1);
   endtask

   initial begin
      mem[0] = 24'h300882; mem[1] = 24'h310303; mem[2] = 24'h0; mem[3] = 24'h0;

      // reset state while rst_in held
      #2;
      check("rst_init_ready", 32'(init_ready), 32'd1);
      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_tvalid", 32'(data_tvalid), 32'd0);
      check("rst_done_err", {30'd0, done, error}, 32'd0);
      check("rst_counters", {entries_written, 14'd0, fail_index}, 32'd0);
      check("rst_bram_addr", 32'(bram_addr), 32'd0);
      @(negedge clk_in); rst_in = 1'b0;
      @(posedge clk_in); #1;
      check("post_rst_ready", 32'(init_ready), 32'd1);

      // basic two-entry table with terminator
      start_run();
      wait_idle("basic", 300);
      expq = '{9'h030, 9'h008, 9'h182, 9'h031, 9'h003, 9'h103};
      check_bytes("basic");
      check("basic_done", done_cnt, 1);
      check("basic_written", 32'(entries_written), 32'd2);
      check("basic_error", 32'(error), 32'd0);
      check("basic_cmds", cmd_cnt, 2);
      check("basic_cmd_fields", 32'(cmd_bad), 32'd0);

      // back-pressure on second byte for 5 cycles
      stall_arm = 1'b1; stall_seen = 0; stall_bad = 0;
      start_run();
      wait_idle("stall", 300);
      check_bytes("stall");
      check("stall_cycles", stall_seen, 5);
      check("stall_bad", stall_bad, 0);
      check("stall_written", 32'(entries_written), 32'd2);

      // two missed ACKs on entry 1, third attempt succeeds
      nack_left = 2;
      start_run();
      wait_idle("retry", 400);
      expq = '{9'h030, 9'h008, 9'h182, 9'h031, 9'h003, 9'h103, 9'h031, 9'h003, 9'h103,
               9'h031, 9'h003, 9'h103};
      check_bytes("retry");
      check("retry_cmds", cmd_cnt, 4);
      check("retry_done", done_cnt, 1);
      check("retry_error", 32'(error), 32'd0);
      check("retry_written", 32'(entries_written), 32'd2);

      // MAX_RETRY+1 missed ACKs on entry 1 -> error
      nack_left = 4;
      start_run();
      wait_idle("fail", 400);
      check("fail_cmds", cmd_cnt, 5);
      check("fail_bytes", gotq.size(), 15);
      check("fail_error", 32'(error), 32'd1);
      check("fail_index", 32'(fail_index), 32'd1);
      check("fail_no_done", done_cnt, 0);
      check("fail_written", 32'(entries_written), 32'd1);
      repeat (3) @(negedge clk_in);
      check("fail_error_sticky", 32'(error), 32'd1);

      // delay entry: 2 ticks of 10 cycles, not counted
      mem[0] = 24'hFFFF02; mem[1] = 24'h123456; mem[2] = 24'h0;
      start_run();
      wait_idle("delay", 300);
      check("delay_gap", gap, 28);
      expq = '{9'h012, 9'h034, 9'h156};
      check_bytes("delay");
      check("delay_written", 32'(entries_written), 32'd1);
      check("delay_error_cleared", 32'(error), 32'd0);
      check("delay_done", done_cnt, 1);

      // full table, no terminator: stop at last index without wrapping
      mem[0] = 24'h010203; mem[1] = 24'h040506; mem[2] = 24'h070809; mem[3] = 24'h0A0B0C;
      start_run();
      wait_idle("full", 500);
      expq = '{9'h001, 9'h002, 9'h103, 9'h004, 9'h005, 9'h106, 9'h007, 9'h008, 9'h109,
               9'h00A, 9'h00B, 9'h10C};
      check_bytes("full");
      check("full_written", 32'(entries_written), 32'd4);
      check("full_done", done_cnt, 1);
      check("full_no_wrap", 32'(wrapped), 32'd0);

      // reset in the middle of sending entry 1
      start_run();
      ended = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk_in);
         if (data_tvalid && entries_written == 16'd1) begin
            ended = 1'b1;
            break;
         end
      end
      check("midsend_reached", 32'(ended), 32'd1);
      check("midsend_tvalid_before", 32'(data_tvalid), 32'd1);
      #1 rst_in = 1'b1;
      #1;
      check("midsend_tvalid", 32'(data_tvalid), 32'd0);
      check("midsend_tlast_cmd", {30'd0, data_tlast, cmd_valid}, 32'd0);
      check("midsend_written", 32'(entries_written), 32'd0);
      check("midsend_bram_addr", 32'(bram_addr), 32'd0);
      check("midsend_ready", 32'(init_ready), 32'd1);
      @(negedge clk_in); rst_in = 1'b0;
      frame_pos = 0;
      @(posedge clk_in); #1;
      check("midsend_post_ready", 32'(init_ready), 32'd1);
      check("midsend_post_tvalid", 32'(data_tvalid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
